// File: rtl/adda_pkg.sv
// Shared definitions for the DA-path sample blocks.
//   state_e        : playback FSM state, encoding visible on state_o
//   midscale()     : DAC code for zero output; also the MSB mask used by the
//                    two's complement to offset-binary conversion
//   UNDERRUN_CNT_W : width of the saturating underrun event counter
package adda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFILL  = 2'd1,
    ST_STREAM   = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_e;

  localparam int UNDERRUN_CNT_W = 16;

  // Offset binary puts zero at 1 << (width-1); plain two's complement at 0.
  function automatic logic [31:0] midscale(input int width, input bit offset_bin);
    return offset_bin ? (32'd1 << (width - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Free-running sample-rate divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : 1 = count; 0 = hold the counter at zero
//   tick       : high for the last clock of each DIV-clock period while run = 1
module rate_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    // NOTE: default assignment first, so every path drives cnt_d and no latch is inferred.
    cnt_d = '0;
    if (run && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: asynchronous active-low reset in the sensitivity list; state updated with <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // With DIV = 1 the counter is pinned at zero and tick follows run.
  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/fifo_dac_reader.sv
// Consumer side of the DA sample FIFO: waits for a prefill level, then reads
// one sample every SAMPLE_DIV clocks, converts it to the DAC code format and
// drives the DAC bus with a one-cycle strobe. Underruns are flagged, counted
// and recovered from by prefilling again.
//   enable        : level, 1 = run playback; 0 returns to IDLE at the next edge
//   fifo_rd_en    : read request pulse; data is valid on fifo_rd_data one cycle later
//   fifo_empty    : FIFO empty flag; fifo_count : FIFO occupancy
//   dac_data      : registered DAC code; dac_strobe : high the first cycle of a new code
//   underrun_flag : sticky, cleared by underrun_clr (a new event wins over clear)
//   underrun_cnt  : saturating underrun event count, cleared only by reset
//   state_o       : IDLE=0, PREFILL=1, STREAM=2, UNDERRUN=3
module fifo_dac_reader
  import adda_pkg::*;
#(
  parameter int DATA_WIDTH    = 14,
  parameter int COUNT_WIDTH   = 6,
  parameter int SAMPLE_DIV    = 4,
  parameter int PREFILL_LEVEL = 32,
  parameter int OFFSET_BIN    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  input  logic                      fifo_empty,
  input  logic [COUNT_WIDTH-1:0]    fifo_count,
  output logic [DATA_WIDTH-1:0]     dac_data,
  output logic                      dac_strobe,
  output logic                      underrun_flag,
  input  logic                      underrun_clr,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt,
  output logic [1:0]                state_o
);

  // Midscale doubles as the conversion mask: flipping the MSB maps two's
  // complement onto offset binary, and a zero mask passes data through.
  localparam logic [DATA_WIDTH-1:0]  MIDSCALE    = DATA_WIDTH'(midscale(DATA_WIDTH, OFFSET_BIN != 0));
  localparam logic [COUNT_WIDTH-1:0] PREFILL_THR = COUNT_WIDTH'(PREFILL_LEVEL);

  state_e                      state_q, state_d;
  logic                        rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0]       dac_data_q, dac_data_d;
  logic                        dac_strobe_q, dac_strobe_d;
  logic                        underrun_flag_q, underrun_flag_d;
  logic [UNDERRUN_CNT_W-1:0]   underrun_cnt_q, underrun_cnt_d;

  logic tick;
  logic rd_req;
  logic underrun_evt;
  logic prefilled;

  // The divider only runs in STREAM, so tick already implies STREAM and each
  // fresh entry into STREAM starts a full SAMPLE_DIV period.
  rate_divider #(
    .DIV (SAMPLE_DIV)
  ) u_rate_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q == ST_STREAM),
    .tick  (tick)
  );

  // Read requests are gated by fifo_empty so the FIFO can never underflow.
  assign rd_req       = tick && !fifo_empty;
  assign underrun_evt = tick &&  fifo_empty;
  assign prefilled    = (fifo_count >= PREFILL_THR);

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:     state_d = ST_PREFILL;
        ST_PREFILL:  if (prefilled)    state_d = ST_STREAM;
        ST_STREAM:   if (underrun_evt) state_d = ST_UNDERRUN;
        ST_UNDERRUN: if (prefilled)    state_d = ST_STREAM;
        default:     state_d = ST_IDLE;
      endcase
    end

    // A read issued last cycle lands on fifo_rd_data now, independent of the
    // current state, so a read in flight when enable drops is still played.
    rd_pend_d    = rd_req;
    dac_strobe_d = rd_pend_q;
    dac_data_d   = rd_pend_q ? (fifo_rd_data ^ MIDSCALE) : dac_data_q;

    underrun_flag_d = underrun_flag_q;
    if (underrun_evt)      underrun_flag_d = 1'b1;
    else if (underrun_clr) underrun_flag_d = 1'b0;

    underrun_cnt_d = underrun_cnt_q;
    if (underrun_evt && (underrun_cnt_q != '1)) underrun_cnt_d = underrun_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      rd_pend_q       <= 1'b0;
      dac_data_q      <= MIDSCALE;
      dac_strobe_q    <= 1'b0;
      underrun_flag_q <= 1'b0;
      underrun_cnt_q  <= '0;
    end else begin
      state_q         <= state_d;
      rd_pend_q       <= rd_pend_d;
      dac_data_q      <= dac_data_d;
      dac_strobe_q    <= dac_strobe_d;
      underrun_flag_q <= underrun_flag_d;
      underrun_cnt_q  <= underrun_cnt_d;
    end
  end

  assign fifo_rd_en    = rd_req;
  assign dac_data      = dac_data_q;
  assign dac_strobe    = dac_strobe_q;
  assign underrun_flag = underrun_flag_q;
  assign underrun_cnt  = underrun_cnt_q;
  assign state_o       = state_q;

endmodule
